// File: rtl/qed_misr_pkg.sv
// Shared types and default constants for the MCU boundary MISR compactors.
package qed_misr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } misr_state_t;

    // Defaults for the MCU input-side (101-bit) and output-side (93-bit) instances.
    localparam logic [100:0] POLY_W101 = 101'h5;
    localparam logic [100:0] SEED_W101 = '0;
    localparam logic [92:0]  POLY_W93  = 93'h5;
    localparam logic [92:0]  SEED_W93  = '0;

endpackage

// File: rtl/misr_lane.sv
// One MISR lane: shift-left with polynomial feedback on MSB, XOR-folding the lane data.
module misr_lane #(
    parameter int unsigned      SIG_W = 101,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(5),
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_seed,
    input  logic             upd,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig;
        if (load_seed) begin
            sig_d = SEED;
        end else if (upd) begin
            sig_d = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= SEED;
        end else begin
            sig <= sig_d;
        end
    end

endmodule

// File: rtl/mcu_misr_compactor.sv
// Multi-lane MISR compactor: window FSM and cycle counter driving NUM_CH misr_lane instances.
module mcu_misr_compactor
    import qed_misr_pkg::*;
#(
    parameter int unsigned      NUM_CH = 8,
    parameter int unsigned      SIG_W  = 101,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_W101),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_W101),
    parameter int unsigned      WINDOW = 124
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            misr_reset,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic                            data_vld,
    input  logic [NUM_CH*SIG_W-1:0]         data_in,
    output logic [NUM_CH*SIG_W-1:0]         sig_out,
    output logic                            sig_done,
    output logic                            busy,
    output logic [$clog2(WINDOW+1)-1:0]     cycle_cnt
);

    localparam int unsigned CNT_W = $clog2(WINDOW + 1);

    misr_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_seed;
    logic             upd_run;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_seed = 1'b0;
        upd_run   = 1'b0;
        if (misr_reset) begin
            // Restart beats everything, including the last RUN cycle.
            state_d   = RUN;
            cnt_d     = '0;
            load_seed = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    upd_run = data_vld;
                    if (cnt_q == CNT_W'(WINDOW - 1)) begin
                        state_d = DONE;
                        cnt_d   = CNT_W'(WINDOW);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sig_done  = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign cycle_cnt = cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        misr_lane #(
            .SIG_W (SIG_W),
            .POLY  (POLY),
            .SEED  (SEED)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load_seed (load_seed),
            .upd       (upd_run & ch_en[i]),
            .data      (data_in[i*SIG_W +: SIG_W]),
            .sig       (sig_out[i*SIG_W +: SIG_W])
        );
    end

endmodule

// File: tb/tb_mcu_misr_compactor.sv
// Scoreboard bench for mcu_misr_compactor: 2 lanes x 8 bits, POLY=1D, WINDOW=4, SEED 00 and 01.
module tb_mcu_misr_compactor;

    typedef struct packed {
        logic [15:0] sig;
        logic        done;
        logic        busy;
        logic [2:0]  cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        misr_reset = 1'b0;
    logic [1:0]  ch_en = 2'b00;
    logic        data_vld = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] sig_out0, sig_out1;
    logic        sig_done0, sig_done1, busy0, busy1;
    logic [2:0]  cycle_cnt0, cycle_cnt1;

    obs_t exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mcu_misr_compactor #(
        .NUM_CH (2), .SIG_W (8), .POLY (8'h1D), .SEED (8'h00), .WINDOW (4)
    ) dut0 (
        .clk (clk), .rst (rst), .misr_reset (misr_reset), .ch_en (ch_en),
        .data_vld (data_vld), .data_in (data_in), .sig_out (sig_out0),
        .sig_done (sig_done0), .busy (busy0), .cycle_cnt (cycle_cnt0)
    );

    mcu_misr_compactor #(
        .NUM_CH (2), .SIG_W (8), .POLY (8'h1D), .SEED (8'h01), .WINDOW (4)
    ) dut1 (
        .clk (clk), .rst (rst), .misr_reset (misr_reset), .ch_en (ch_en),
        .data_vld (data_vld), .data_in (data_in), .sig_out (sig_out1),
        .sig_done (sig_done1), .busy (busy1), .cycle_cnt (cycle_cnt1)
    );

    function automatic obs_t mk(logic [15:0] s, logic d, logic b, logic [2:0] c);
        obs_t o;
        o.sig = s; o.done = d; o.busy = b; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t obs0();
        return {sig_out0, sig_done0, busy0, cycle_cnt0};
    endfunction

    function automatic obs_t obs1();
        return {sig_out1, sig_done1, busy1, cycle_cnt1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        misr_reset = 1'b0; ch_en = 2'b11; data_vld = 1'b0; data_in = '0;
        rst = 1'b0;
        #12;
        exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(16'h0101, 1'b0, 1'b0, 3'd0));
        got = obs0(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_dut0: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                     got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
        end
        got = obs1(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_dut1: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                     got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
        end
        tick();
        rst = 1'b1;
        // Valid data without misr_reset must not move the lanes out of IDLE.
        for (int i = 0; i < 10; i++) begin
            data_vld = 1'b1;
            data_in  = 16'($urandom);
            exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 3'd0));
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    task automatic test_window();
        logic [7:0] l0 [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        obs_t exp [10];
        obs_t got, want;
        exp = '{mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0080, 1'b0, 1'b1, 3'd1),
                mk(16'h001D, 1'b0, 1'b1, 3'd2), mk(16'h003A, 1'b0, 1'b1, 3'd3),
                mk(16'h0074, 1'b1, 1'b0, 3'd4), mk(16'h0074, 1'b1, 1'b0, 3'd4),
                mk(16'h0074, 1'b1, 1'b0, 3'd4), mk(16'h0074, 1'b1, 1'b0, 3'd4),
                mk(16'h0074, 1'b1, 1'b0, 3'd4), mk(16'h0074, 1'b1, 1'b0, 3'd4)};
        for (int i = 0; i < 10; i++) begin
            misr_reset = (i == 0);
            data_vld   = 1'b1;
            ch_en      = (i >= 5) ? 2'($urandom) : 2'b11;
            data_in    = (i >= 5) ? 16'($urandom) : {8'h00, l0[i]};
            exp_q.push_back(exp[i]);
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL window[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    task automatic test_seed();
        obs_t exp [5];
        obs_t got, want;
        exp = '{mk(16'h0101, 1'b0, 1'b1, 3'd0), mk(16'h0202, 1'b0, 1'b1, 3'd1),
                mk(16'h0404, 1'b0, 1'b1, 3'd2), mk(16'h0808, 1'b0, 1'b1, 3'd3),
                mk(16'h1010, 1'b1, 1'b0, 3'd4)};
        for (int i = 0; i < 5; i++) begin
            misr_reset = (i == 0);
            data_vld   = 1'b1;
            ch_en      = 2'b11;
            data_in    = 16'h0000;
            exp_q.push_back(exp[i]);
            tick();
            got = obs1(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL seed01[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    task automatic test_ch_en();
        logic [7:0] l0 [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        obs_t exp [5];
        obs_t got, want;
        exp = '{mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0080, 1'b0, 1'b1, 3'd1),
                mk(16'h001D, 1'b0, 1'b1, 3'd2), mk(16'h003A, 1'b0, 1'b1, 3'd3),
                mk(16'h0074, 1'b1, 1'b0, 3'd4)};
        for (int i = 0; i < 5; i++) begin
            misr_reset = (i == 0);
            data_vld   = 1'b1;
            ch_en      = 2'b01;
            data_in    = {8'hFF, l0[i]};
            exp_q.push_back(exp[i]);
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ch_en[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    task automatic test_vld_gap();
        logic        vld [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] din [5] = '{16'h0000, 16'h0080, 16'hFFFF, 16'hFFFF, 16'h0000};
        obs_t exp [5];
        obs_t got, want;
        exp = '{mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0080, 1'b0, 1'b1, 3'd1),
                mk(16'h0080, 1'b0, 1'b1, 3'd2), mk(16'h0080, 1'b0, 1'b1, 3'd3),
                mk(16'h001D, 1'b1, 1'b0, 3'd4)};
        for (int i = 0; i < 5; i++) begin
            misr_reset = (i == 0);
            data_vld   = vld[i];
            ch_en      = 2'b11;
            data_in    = din[i];
            exp_q.push_back(exp[i]);
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL vld_gap[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    // Restart on the final RUN cycle, a held misr_reset, then a restart out of DONE.
    task automatic test_back_to_back();
        logic       mr [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] l0 [13] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80,
                                8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
        obs_t exp [13];
        obs_t got, want;
        exp = '{mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0080, 1'b0, 1'b1, 3'd1),
                mk(16'h001D, 1'b0, 1'b1, 3'd2), mk(16'h003A, 1'b0, 1'b1, 3'd3),
                mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0000, 1'b0, 1'b1, 3'd0),
                mk(16'h0000, 1'b0, 1'b1, 3'd0), mk(16'h0080, 1'b0, 1'b1, 3'd1),
                mk(16'h001D, 1'b0, 1'b1, 3'd2), mk(16'h003A, 1'b0, 1'b1, 3'd3),
                mk(16'h0074, 1'b1, 1'b0, 3'd4), mk(16'h0000, 1'b0, 1'b1, 3'd0),
                mk(16'h0080, 1'b0, 1'b1, 3'd1)};
        for (int i = 0; i < 13; i++) begin
            misr_reset = mr[i];
            data_vld   = 1'b1;
            ch_en      = 2'b11;
            data_in    = {8'h00, l0[i]};
            exp_q.push_back(exp[i]);
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL restart[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    task automatic test_async_rst();
        obs_t got, want;
        // Leave dut0 mid-window at 1D / cnt 2 from the previous task's 80 then step once more.
        data_in = 16'h0000; misr_reset = 1'b0; data_vld = 1'b1;
        exp_q.push_back(mk(16'h001D, 1'b0, 1'b1, 3'd2));
        tick();
        got = obs0(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL pre_rst: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                     got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
        end
        #2;
        rst = 1'b0;
        exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(mk(16'h0101, 1'b0, 1'b0, 3'd0));
        #1;
        got = obs0(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_rst_dut0: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                     got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
        end
        got = obs1(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_rst_dut1: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                     got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 16'h8080;
            exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 3'd0));
            tick();
            got = obs0(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL post_rst_idle[%0d]: got sig=%h done=%b busy=%b cnt=%0d, want sig=%h done=%b busy=%b cnt=%0d",
                         i, got.sig, got.done, got.busy, got.cnt, want.sig, want.done, want.busy, want.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_seed();
        test_ch_en();
        test_vld_gap();
        test_back_to_back();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
